fetch_buffer: RTL and testbench
===============================

// Module: fetch_buffer
// PURPOSE
//  Write-side producer queue between the fetch stage and decode. Fetch pushes 128-bit
//  instruction bundles plus fetch_to_decode params. Decode pops them over the
//  fetch_rd_en / fetch_rd_valid / fetch_empty protocol.
//  Read data is registered: one-cycle read latency. ci_flush empties the queue on redirect.
// PARAMETERS
//  DATA_WIDTH    128  bundle width in bits (4 x 32-bit instructions)
//  DEPTH         8    entries; power of two, >= 2
//  AFULL_MARGIN  2    almost_full asserts when count >= DEPTH-AFULL_MARGIN
// PORTS
//  clk             in   1            clock
//  rst_n           in   1            asynchronous active-low reset
//  ci_flush        in   1            commit-initiated flush; clears queue
//  wr_en           in   1            push request from fetch
//  wr_instr        in   DATA_WIDTH   bundle to push
//  wr_param        in   PARAM_W      fifo_fetch_to_decode_param_t {pc[39:0], fault}
//  full            out  1            no free entry
//  almost_full     out  1            fetch throttle hint
//  count           out  $clog2(DEPTH)+1  current occupancy
//  fetch_rd_en     in   1            pop request from decode
//  fetch_rd_valid  out  1            fetch_instr/fetch_param valid this cycle
//  fetch_instr     out  DATA_WIDTH   popped bundle
//  fetch_param     out  PARAM_W      popped params
//  fetch_empty     out  1            no readable entry
// BEHAVIOUR
//  - Reset (async, rst_n=0): pointers, count, fetch_rd_valid, fetch_instr and fetch_param
//    are 0; fetch_empty=1, full=0, almost_full=0. Storage array is not reset.
//  - Pointers are $clog2(DEPTH)+1 bits wide (wrap bit). empty when ptrs are equal.
//    full when indices are equal and wrap bits differ.
//  - Push accepted iff wr_en & !full & !ci_flush. wr_en while full: dropped silently.
//    Fetch must not rely on a dropped push; it must honour full.
//  - Pop accepted iff fetch_rd_en & !fetch_empty & !ci_flush. Entry is registered to
//    fetch_instr/param with fetch_rd_valid=1 on the NEXT cycle.
//    A non-accepted cycle gives fetch_rd_valid=0 next cycle; outputs hold their last value.
//  - Back-to-back pops deliver one entry per cycle, in order.
//  - Simultaneous push+pop when not empty and not full: both occur; count unchanged.
//    When full, push is rejected even if a pop occurs in the same cycle.
//  - full, fetch_empty, almost_full and count are registered-state derived.
//    They update the cycle after the causing push/pop.
//  - ci_flush: next cycle pointers=0, count=0, fetch_rd_valid=0, fetch_empty=1.
//    Push and pop in the flush cycle are discarded. A pop already in flight from the
//    prior cycle still presents fetch_rd_valid=1 in the flush cycle; decode discards it.
//  - Reset mid-operation: immediate return to the reset state, no partial entry kept.
// CONFIGURATION
//  FETCH_BUF_BYPASS_EN defined:
//    when fetch_empty=1 and wr_en & fetch_rd_en & !ci_flush in the same cycle,
//    wr_instr/wr_param go straight to the output register. fetch_rd_valid=1 next cycle.
//    Pointers and count are unchanged (zero added latency).
//  Undefined: the pop in that case is ignored (fetch_rd_valid=0 next cycle).
//    The push is stored normally; it becomes readable the following cycle.
// STRUCTURE
//  - Shared core package: fifo_fetch_to_decode_param_t (PARAM_W = $bits of it, 41)
//    and PC_WIDTH=40.
//  - Sub-module fetch_buffer_ram: DEPTH x (DATA_WIDTH+PARAM_W) simple dual-port array.
//    One write port, one read port, registered read. Pointer/flag logic lives in
//    fetch_buffer.
// TESTING
//  1 Reset then idle -> fetch_empty=1, full=0, count=0, fetch_rd_valid=0 for 10 cycles.
//  2 Push 3 bundles, pc 0x10000/0x10010/0x10020; then pop x3 back-to-back
//    -> fetch_rd_valid on 3 consecutive cycles, params {pc,0} in order; empty after.
//  3 Push 8 (DEPTH) -> full=1, almost_full set after 6th push; 9th push (pc 0x10080)
//    dropped; drain 8 -> last pc=0x10070.
//  4 Steady-state: push+pop every cycle for 20 cycles with 2 entries resident
//    -> count stays 2; output pc sequence strictly +0x10.
//  5 Fill 5 entries, assert ci_flush with wr_en and fetch_rd_en high
//    -> next cycle count=0, fetch_empty=1; no further fetch_rd_valid.
//  6 Empty, wr_en+fetch_rd_en with pc 0x20000
//    -> with FETCH_BUF_BYPASS_EN: fetch_rd_valid=1 next cycle, count stays 0.
//    -> without: fetch_rd_valid=0, count=1, then popped next.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-to-decode types used by the fetch buffer and its bench.
package fetch_buffer_pkg;

    localparam int PC_WIDTH = 40;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                fault;
    } fifo_fetch_to_decode_param_t;

    localparam int PARAM_W = $bits(fifo_fetch_to_decode_param_t);

endpackage

// File: rtl/fetch_buffer_ram.sv
// Simple dual-port storage for the fetch buffer: one write port and one read port.
// The read port has a registered output that can load the write data directly.
module fetch_buffer_ram #(
    parameter int WIDTH = 169,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             rd_bypass,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= rd_bypass ? wr_data : mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fetch_buffer.sv
// Fetch-to-decode bundle queue with one-cycle registered read and flush on redirect.
// Define FETCH_BUF_BYPASS_EN to let a push into an empty queue pop in the same cycle.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ci_flush,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_instr,
    input  logic [PARAM_W-1:0]      wr_param,
    output logic                    full,
    output logic                    almost_full,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    fetch_rd_en,
    output logic                    fetch_rd_valid,
    output logic [DATA_WIDTH-1:0]   fetch_instr,
    output logic [PARAM_W-1:0]      fetch_param,
    output logic                    fetch_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + PARAM_W;
    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] AFULL_THR = (AW+1)'(DEPTH - AFULL_MARGIN);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic          push_acc, pop_acc, bypass;
    logic [EW-1:0] ram_rd_data;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign fetch_empty = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                         (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count       = wr_ptr_q - rd_ptr_q;
    assign almost_full = (count >= AFULL_THR);

`ifdef FETCH_BUF_BYPASS_EN
    assign bypass = fetch_empty & wr_en & fetch_rd_en & ~ci_flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed bundle goes straight to the output register and is never stored.
    assign push_acc = wr_en & ~full & ~ci_flush & ~bypass;
    assign pop_acc  = fetch_rd_en & ~fetch_empty & ~ci_flush;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = pop_acc | bypass;
        if (ci_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    fetch_buffer_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push_acc),
        .wr_addr   (wr_ptr_q[AW-1:0]),
        .wr_data   ({wr_instr, wr_param}),
        .rd_en     (pop_acc | bypass),
        .rd_bypass (bypass),
        .rd_addr   (rd_ptr_q[AW-1:0]),
        .rd_data   (ram_rd_data)
    );

    assign fetch_rd_valid = rd_valid_q;
    assign fetch_instr    = ram_rd_data[EW-1:PARAM_W];
    assign fetch_param    = ram_rd_data[PARAM_W-1:0];

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a queue scoreboard of expected popped entries.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DW    = 128;
    localparam int DEPTH = 8;
`ifdef FETCH_BUF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ci_flush = 1'b0;
    logic wr_en = 1'b0;
    logic fetch_rd_en = 1'b0;
    logic [DW-1:0] wr_instr = '0;
    logic [PARAM_W-1:0] wr_param = '0;
    logic full, almost_full, fetch_rd_valid, fetch_empty;
    logic [3:0] count;
    logic [DW-1:0] fetch_instr;
    logic [PARAM_W-1:0] fetch_param;

    typedef struct packed {
        logic [DW-1:0]      instr;
        logic [PARAM_W-1:0] param;
    } entry_t;

    entry_t mem_q[$];
    entry_t out_q[$];
    int model_count = 0;
    int checks = 0;
    int failures = 0;
    logic [39:0] last_pc = '0;
    bit track_inc = 1'b0;

    always #5 clk = ~clk;

    fetch_buffer #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_MARGIN (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ci_flush       (ci_flush),
        .wr_en          (wr_en),
        .wr_instr       (wr_instr),
        .wr_param       (wr_param),
        .full           (full),
        .almost_full    (almost_full),
        .count          (count),
        .fetch_rd_en    (fetch_rd_en),
        .fetch_rd_valid (fetch_rd_valid),
        .fetch_instr    (fetch_instr),
        .fetch_param    (fetch_param),
        .fetch_empty    (fetch_empty)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit we, input bit re, input bit fl, input logic [39:0] pc);
        wr_en       = we;
        fetch_rd_en = re;
        ci_flush    = fl;
        wr_param    = {pc, 1'b0};
        wr_instr    = {pc[31:0] ^ 32'hA5A5_0000, pc[31:0] + 32'd4, pc[31:0] + 32'd8, pc[31:0] + 32'd12};
    endtask

    task automatic cycle_chk();
        entry_t e, got;
        bit byp, push_ok, pop_ok, exp_valid;
        e.instr = wr_instr;
        e.param = wr_param;
        byp     = BYPASS && model_count == 0 && wr_en && fetch_rd_en && !ci_flush;
        push_ok = wr_en && model_count < DEPTH && !ci_flush && !byp;
        pop_ok  = fetch_rd_en && model_count > 0 && !ci_flush;
        if (pop_ok) out_q.push_back(mem_q.pop_front());
        if (byp) out_q.push_back(e);
        if (push_ok) mem_q.push_back(e);
        if (ci_flush) mem_q.delete();
        model_count = mem_q.size();
        exp_valid = pop_ok || byp;
        @(posedge clk);
        #1;
        chk("rd_valid", 256'(fetch_rd_valid), 256'(exp_valid));
        if (fetch_rd_valid === 1'b1) begin
            if (out_q.size() == 0) begin
                chk("unexpected_pop", 256'(fetch_rd_valid), 256'(1'b0));
            end else begin
                got = out_q.pop_front();
                chk("instr", 256'(fetch_instr), 256'(got.instr));
                chk("param", 256'(fetch_param), 256'(got.param));
                if (track_inc) chk("pc_inc", 256'(fetch_param[40:1]), 256'(last_pc + 40'h10));
                last_pc = fetch_param[40:1];
            end
        end
        chk("count", 256'(count), 256'(model_count));
        chk("empty", 256'(fetch_empty), 256'(model_count == 0));
        chk("full", 256'(full), 256'(model_count == DEPTH));
        chk("almost_full", 256'(almost_full), 256'(model_count >= DEPTH - 2));
        $display("cyc we=%0b re=%0b fl=%0b pc=%0h -> valid=%0b out_pc=%0h count=%0d",
                 wr_en, fetch_rd_en, ci_flush, wr_param[40:1], fetch_rd_valid, fetch_param[40:1], count);
    endtask

    initial begin
        // 1: reset values, then idle
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 256'(fetch_empty), 256'(1'b1));
        chk("rst_full", 256'(full), 256'(1'b0));
        chk("rst_afull", 256'(almost_full), 256'(1'b0));
        chk("rst_count", 256'(count), 256'(0));
        chk("rst_valid", 256'(fetch_rd_valid), 256'(1'b0));
        chk("rst_instr", 256'(fetch_instr), 256'(0));
        chk("rst_param", 256'(fetch_param), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 0, 40'h0);
        repeat (10) cycle_chk();

        // 2: three pushes, three back-to-back pops
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 0, 40'h10000 + 40'(i * 16));
            cycle_chk();
        end
        set_in(0, 1, 0, 40'h0);
        repeat (3) cycle_chk();
        set_in(0, 0, 0, 40'h0);
        cycle_chk();
        chk("t2_last_pc", 256'(last_pc), 256'(40'h10020));

        // 3: fill to full, dropped ninth push, drain
        for (int i = 0; i < 9; i++) begin
            set_in(1, 0, 0, 40'h10000 + 40'(i * 16));
            cycle_chk();
            if (i == 5) chk("t3_afull_at6", 256'(almost_full), 256'(1'b1));
        end
        chk("t3_full", 256'(full), 256'(1'b1));
        set_in(0, 1, 0, 40'h0);
        repeat (8) cycle_chk();
        set_in(0, 0, 0, 40'h0);
        cycle_chk();
        chk("t3_last_pc", 256'(last_pc), 256'(40'h10070));

        // 4: steady-state push+pop with two entries resident
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 40'h30000 + 40'(i * 16));
            cycle_chk();
        end
        last_pc = 40'h30000 - 40'h10;
        track_inc = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(1, 1, 0, 40'h30020 + 40'(i * 16));
            cycle_chk();
            chk("t4_count", 256'(count), 256'(2));
        end
        set_in(0, 1, 0, 40'h0);
        repeat (2) cycle_chk();
        track_inc = 1'b0;
        set_in(0, 0, 0, 40'h0);
        cycle_chk();

        // 5: flush with push and pop requested
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 40'h40000 + 40'(i * 16));
            cycle_chk();
        end
        set_in(1, 1, 1, 40'h40050);
        cycle_chk();
        chk("t5_count", 256'(count), 256'(0));
        chk("t5_empty", 256'(fetch_empty), 256'(1'b1));
        set_in(0, 1, 0, 40'h0);
        repeat (3) cycle_chk();

        // 6: push and pop together on an empty queue
        set_in(1, 1, 0, 40'h20000);
        cycle_chk();
        chk("t6_count", 256'(count), 256'(BYPASS ? 0 : 1));
        chk("t6_valid", 256'(fetch_rd_valid), 256'(BYPASS));
        set_in(0, 1, 0, 40'h0);
        cycle_chk();
        chk("t6_pc", 256'(fetch_param[40:1]), 256'(40'h20000));
        set_in(0, 0, 0, 40'h0);
        cycle_chk();

        // Reset mid-operation
        for (int i = 0; i < 2; i++) begin
            set_in(1, 0, 0, 40'h50000 + 40'(i * 16));
            cycle_chk();
        end
        set_in(0, 1, 0, 40'h0);
        cycle_chk();
        set_in(0, 0, 0, 40'h0);
        rst_n = 1'b0;
        #1;
        mem_q.delete();
        out_q.delete();
        model_count = 0;
        chk("mrst_count", 256'(count), 256'(0));
        chk("mrst_empty", 256'(fetch_empty), 256'(1'b1));
        chk("mrst_valid", 256'(fetch_rd_valid), 256'(1'b0));
        chk("mrst_param", 256'(fetch_param), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 1, 0, 40'h0);
        repeat (2) cycle_chk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
